// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle control FSM for an RV32I core: sequences fetch/decode/exec/mem/wb,
// drives all datapath enables and selects, and halts with a sticky trap cause.
module rv32i_mc_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        br_taken_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_addr_sel_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic        reg_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        alu_a_sel_o,
  output logic        alu_b_sel_o,
  output logic        retire_o,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o,
  output logic [2:0]  state_o
);

  // FETCH=0 read instr | DECODE=1 latch opcode | EXEC=2 alu/branch | MEM=3 data access | WB=4 writeback | TRAP=5 halted
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int              CW       = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [CW-1:0]   TO_LIMIT = CW'(MEM_TIMEOUT);

  logic [2:0]    state_q, state_d;
  logic [6:0]    opcode_q, opcode_d;
  logic          rd_zero_q, rd_zero_d;
  logic [1:0]    cause_q, cause_d;
  logic [CW-1:0] tmo_q, tmo_d;

  logic          legal_op, timeout;
  logic          mreq, mwe, asel, irwe, pcwe, regwe, alu_a, alu_b;
  logic [1:0]    pcsel, wbsel;
  logic          unused_instr;

  assign unused_instr = ^instr_i[31:12];

  always_comb begin
    case (instr_i[6:0])
      OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE: legal_op = 1'b1;
      default:                                      legal_op = 1'b0;
    endcase
  end

  // The limit cycle still honours a same-cycle mem_ready.
  assign timeout = (MEM_TIMEOUT != 0) && (tmo_q == TO_LIMIT) && !mem_ready_i;
  assign tmo_d   = (mreq && !mem_ready_i) ? tmo_q + CW'(1) : '0;

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    rd_zero_d = rd_zero_q;
    cause_d   = cause_q;
    mreq      = 1'b0;
    mwe       = 1'b0;
    asel      = 1'b0;
    irwe      = 1'b0;
    pcwe      = 1'b0;
    pcsel     = 2'd0;
    regwe     = 1'b0;
    wbsel     = 2'd0;
    case (state_q)
      S_FETCH: begin
        mreq = 1'b1;
        if (mem_ready_i) begin
          irwe    = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end
      end
      S_DECODE: begin
        opcode_d  = instr_i[6:0];
        rd_zero_d = (instr_i[11:7] == 5'd0);
        if (instr_i[6:0] == OP_SYSTEM) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end else if (legal_op) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode_q)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH: begin
            pcwe  = 1'b1;
            pcsel = br_taken_i ? 2'd1 : 2'd0;
          end
          OP_JAL: begin
            regwe = 1'b1;
            wbsel = 2'd2;
            pcwe  = 1'b1;
            pcsel = 2'd1;
          end
          OP_JALR: begin
            regwe = 1'b1;
            wbsel = 2'd2;
            pcwe  = 1'b1;
            pcsel = 2'd2;
          end
          OP_LUI: begin
            regwe = 1'b1;
            wbsel = 2'd3;
            pcwe  = 1'b1;
          end
          OP_FENCE: pcwe = 1'b1;
          default:  state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mreq = 1'b1;
        asel = 1'b1;
        mwe  = (opcode_q == OP_STORE);
        if (mem_ready_i) begin
          if (opcode_q == OP_STORE) begin
            pcwe    = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end
      end
      S_WB: begin
        regwe   = 1'b1;
        wbsel   = (opcode_q == OP_LOAD) ? 2'd1 : 2'd0;
        pcwe    = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Operand selects stay stable from EXEC through MEM and WB.
  always_comb begin
    alu_a = 1'b0;
    alu_b = 1'b0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (opcode_q)
        OP_IMM, OP_LOAD, OP_STORE, OP_JALR: alu_b = 1'b1;
        OP_AUIPC: begin
          alu_a = 1'b1;
          alu_b = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      opcode_q  <= 7'd0;
      rd_zero_q <= 1'b0;
      cause_q   <= 2'd0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      rd_zero_q <= rd_zero_d;
      cause_q   <= cause_d;
      tmo_q     <= tmo_d;
    end
  end

  assign mem_req_o      = mreq & ~rst_i;
  assign mem_we_o       = mwe & ~rst_i;
  assign mem_addr_sel_o = asel & ~rst_i;
  assign ir_we_o        = irwe & ~rst_i;
  assign pc_we_o        = pcwe & ~rst_i;
  assign pc_sel_o       = rst_i ? 2'd0 : pcsel;
  assign reg_we_o       = regwe & ~rd_zero_q & ~rst_i;
  assign wb_sel_o       = rst_i ? 2'd0 : wbsel;
  assign alu_a_sel_o    = alu_a & ~rst_i;
  assign alu_b_sel_o    = alu_b & ~rst_i;
  assign retire_o       = pc_we_o;
  assign trap_o         = (state_q == S_TRAP) & ~rst_i;
  assign trap_cause_o   = cause_q;
  assign state_o        = state_q;

endmodule
